// File: rtl/logic_gate_pkg.sv
// Shared op encoding for the logic gate pipeline.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_BUF  = 3'b111
  } op_e;

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise gate function selected by op.
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] z
);

  always_comb begin
    z = '0;
    case (op_e'(op))
      OP_NOT:  z = ~a;
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_NAND: z = ~(a & b);
      OP_NOR:  z = ~(a | b);
      OP_XNOR: z = ~(a ^ b);
      OP_BUF:  z = a;
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Logic gate with a 2-entry result FIFO and valid/ready handshakes.
// Define LGP_PARITY_EN to add the out_par even-parity output.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z
`ifdef LGP_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] alu_z;
  logic [WIDTH-1:0] tail_z;
  logic [1:0]       count;
  logic             ready_q;
  logic             push;
  logic             pop;

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a),
    .b  (b),
    .op (op),
    .z  (alu_z)
  );

  // out_z is the FIFO head register itself, so it naturally holds its last
  // value once the FIFO drains; ready_q keeps in_ready low until the first
  // edge after reset release.
  assign in_ready  = ready_q && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      ready_q <= 1'b0;
      out_z   <= '0;
      tail_z  <= '0;
    end else begin
      ready_q <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_z <= alu_z;
          else               tail_z <= alu_z;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) out_z <= tail_z;
          count <= count - 2'd1;
        end
        2'b11: out_z <= alu_z;
        default: ;
      endcase
    end
  end

`ifdef LGP_PARITY_EN
  logic tail_par;

  // Parity is stored per entry and follows out_z through the same moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par  <= 1'b0;
      tail_par <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_par <= ^alu_z;
          else               tail_par <= ^alu_z;
        end
        2'b01: if (count == 2'd2) out_par <= tail_par;
        2'b11: out_par <= ^alu_z;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (WIDTH=5), with or without LGP_PARITY_EN.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_z;
`ifdef LGP_PARITY_EN
  logic       out_par;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  logic       mon_v;
  logic       mon_r;
  logic [4:0] mon_z;
  logic       mon_p;

  logic [3:0] tt_table [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                               4'b0111, 4'b0001, 4'b1001, 4'b1100};
  logic [4:0] sweep_exp [8] = '{5'b00110, 5'b10001, 5'b11101, 5'b01100,
                                5'b01110, 5'b00010, 5'b10011, 5'b11001};

  logic_gate_pipe #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z)
`ifdef LGP_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [4:0] refModel(input logic [2:0] fop, input logic [4:0] fa,
                                          input logic [4:0] fb);
    logic [3:0] tt;
    logic [4:0] r;
    tt = tt_table[fop];
    for (int i = 0; i < 5; i++) r[i] = tt[{fa[i], fb[i]}];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ta, input logic [4:0] tb_v,
                               input logic [2:0] top, output bit acc);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op       = top;
    @(negedge clk);
    acc = in_ready;
    if (acc) exp_q.push_back(refModel(top, ta, tb_v));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idleCycle();
      n++;
    end
    checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    idleCycle();
  endtask

  // Monitor: compares the head of the DUT against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_v = out_valid;
      mon_r = out_ready;
      mon_z = out_z;
`ifdef LGP_PARITY_EN
      mon_p = out_par;
`else
      mon_p = ^out_z;
`endif
      #1;
      if (mon_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got out_valid=1 z=%0h expected no result", mon_z);
        end else begin
          checkOutput("out_z", 64'(mon_z), 64'(exp_q[0]));
          checkOutput("out_par", 64'(mon_p), 64'(^exp_q[0]));
          if (mon_r) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [2:0] rop;
    logic [4:0] first_exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = '0;

    // Reset state.
    repeat (2) idleCycle();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_z", 64'(out_z), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef LGP_PARITY_EN
    checkOutput("rst_out_par", 64'(out_par), 64'd0);
`endif
    #2 rst_n = 1'b1;
    idleCycle();
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);

    // Single NOT with one-cycle latency.
    out_ready = 1'b1;
    applyStimulus(5'b10110, 5'b00000, OP_NOT, acc);
    checkOutput("lat_out_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_out_z", 64'(out_z), 64'(5'b01001));
`ifdef LGP_PARITY_EN
    checkOutput("lat_out_par", 64'(out_par), 64'd0);
`endif
    waitDrain();

    // Op sweep back-to-back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'b11001, 5'b10101, 3'(i), acc);
      checkOutput($sformatf("sweep_op%0d", i), 64'(out_z), 64'(sweep_exp[i]));
    end
    waitDrain();

    // Back-pressure: third push must be refused and head must hold.
    out_ready = 1'b0;
    first_exp = refModel(OP_XOR, 5'b00111, 5'b01010);
    applyStimulus(5'b00111, 5'b01010, OP_XOR, acc);
    checkOutput("bp_acc1", 64'(acc), 64'd1);
    applyStimulus(5'b11100, 5'b00110, OP_AND, acc);
    checkOutput("bp_acc2", 64'(acc), 64'd1);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(5'b10101, 5'b01010, OP_OR, acc);
    checkOutput("bp_acc3", 64'(acc), 64'd0);
    checkOutput("bp_hold_z", 64'(out_z), 64'(first_exp));
    out_ready = 1'b1;
    waitDrain();

    // Ten random operands at full throughput.
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom); rb = 5'($urandom); rop = 3'($urandom);
      applyStimulus(ra, rb, rop, acc);
      checkOutput("tput_acc", 64'(acc), 64'd1);
      checkOutput("tput_out_z", 64'(out_z), 64'(refModel(rop, ra, rb)));
    end
    waitDrain();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 150; i++) begin
      out_ready = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        ra = 5'($urandom); rb = 5'($urandom); rop = 3'($urandom);
        applyStimulus(ra, rb, rop, acc);
      end else begin
        idleCycle();
      end
    end
    out_ready = 1'b1;
    waitDrain();

    // Reset pulsed between edges with a full FIFO.
    out_ready = 1'b0;
    applyStimulus(5'b01111, 5'b10001, OP_NAND, acc);
    applyStimulus(5'b11000, 5'b10100, OP_NOR, acc);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_z", 64'(out_z), 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    idleCycle();
    checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(5'b10010, 5'b00000, OP_BUF, acc);
    checkOutput("postrst_out_z", 64'(out_z), 64'(5'b10010));
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 5, operand and result width in bits (legal range 1..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set on a, b, op is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand; ignored by unary ops.
REQ-008 op  input  3  operation select.
REQ-009 out_valid  output  1  out_z holds a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_z  output  WIDTH  result.
REQ-012 out_par  output  1  even parity of out_z; present only with LGP_PARITY_EN.

Function
REQ-013 Op encoding SHALL be: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 BUF a; all ops bitwise over WIDTH bits.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-015 Results SHALL be computed at input transfer and stored in a 2-entry FIFO; results leave in acceptance order, none dropped or duplicated.
REQ-016 in_ready SHALL be 1 exactly when occupancy < 2 and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when occupancy > 0; out_z SHALL show the oldest entry.
REQ-018 Latency SHALL be 1 cycle: an operand accepted at edge N into an empty FIFO appears on out_z with out_valid=1 after edge N.
REQ-019 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one result per cycle, with occupancy staying at 1.
REQ-020 Simultaneous push and pop at occupancy 1 SHALL keep occupancy at 1, with the new result replacing the popped one.
REQ-021 At occupancy 2, in_ready=0, and inputs SHALL be ignored regardless of in_valid.
REQ-022 Pop at occupancy 0 SHALL be impossible because out_valid=0; out_ready at that time SHALL have no effect.
REQ-023 out_z SHALL hold its value while out_valid=1 and out_ready=0, and it SHALL keep its last value when the FIFO empties.

Reset
REQ-024 While rst_n=0, the block SHALL be in reset: occupancy 0, out_valid=0, out_z=0, out_par=0, FIFO storage cleared.
REQ-025 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all buffered results immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro LGP_PARITY_EN defined, port out_par SHALL exist and SHALL equal the XOR-reduction of out_z, stored alongside each entry.
REQ-028 Without LGP_PARITY_EN, port out_par and its storage SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package logic_gate_pkg SHALL hold the op encoding constants (OP_NOT..OP_BUF) and the op width constant (3).
REQ-030 The combinational function SHALL be a sub-module logic_gate_alu (inputs a, b, op; output z; parameter WIDTH); logic_gate_pipe SHALL hold the FIFO and handshake.

Verification (WIDTH=5)
REQ-031 Reset release, then a=5'b10110, op=NOT, in_valid one cycle, out_ready=1 -> out_valid next cycle with out_z=5'b01001 (out_par=0).
REQ-032 Sweep all 8 ops with a=5'b11001 and b=5'b10101 -> out_z in order: 00110, 10001, 11101, 01100, 01110, 00010, 10011, 11001.
REQ-033 out_ready=0, then push 3 operands on consecutive cycles -> in_ready drops after the 2nd push, the 3rd is not accepted, and out_z holds the 1st result.
REQ-034 out_ready=1, then 10 random operands back-to-back -> 10 results in order, one per cycle, in_ready stays 1.
REQ-035 FIFO holds 2 entries, then rst_n pulsed low between edges -> out_valid=0 immediately, and after release in_ready=1 and no stale results appear.
REQ-036 Build with and without LGP_PARITY_EN -> identical out_z streams; out_par equals the XOR-reduction of out_z whenever out_valid=1.
